// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 key event path.
// Holds the event record layout and the press/release encoding.
package tm1638_pkg;

   localparam int NUM_KEYS  = 8;
   localparam int KEY_IDX_W = 3;
   localparam int EVT_W     = KEY_IDX_W + 1;
   localparam int CNT_W     = 4;

   localparam logic EVT_PRESSED  = 1'b1;
   localparam logic EVT_RELEASED = 1'b0;

   typedef struct packed {
      logic                 pressed;
      logic [KEY_IDX_W-1:0] key_idx;
   } key_evt_t;

   function automatic key_evt_t make_evt(input logic                 level,
                                         input logic [KEY_IDX_W-1:0] idx);
      key_evt_t e;
      e.pressed = level ? EVT_PRESSED : EVT_RELEASED;
      e.key_idx = idx;
      return e;
   endfunction

endpackage

// File: rtl/tm1638_evt_fifo.sv
// First-word-fall-through event queue with wrap-bit pointers.
// A push into a full queue is accepted only when a pop happens on the same cycle.
module tm1638_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_accept,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             empty, full, pop;

   // Equal low bits with differing wrap bits means the writer lapped the reader.
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop       = !empty && rd_ready;
   assign wr_accept = wr_en && (!full || pop);
   assign rd_valid  = !empty;
   assign rd_data   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_accept) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_data;
         wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/tm1638_key_events.sv
// Debounces TM1638 key scans and turns accepted key changes into queued
// press/release events, lowest key index first.
module tm1638_key_events
   import tm1638_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] keys_raw,
   input  logic                keys_valid,
   output logic [NUM_KEYS-1:0] keys_stable,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [EVT_W-1:0]    evt_data,
   output logic                overflow,
   input  logic                clr_overflow
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [NUM_KEYS-1:0]            stable_q, stable_d;
   logic [NUM_KEYS-1:0]            pending_q, pending_d;
   logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                           overflow_q, overflow_d;
   logic [NUM_KEYS-1:0]            toggle, sel_mask;
   logic [KEY_IDX_W-1:0]           sel_idx;
   logic                           found, push_ok;
   key_evt_t                       push_evt;

   // A key flips only after DEBOUNCE_SCANS consecutive differing scans.
   always_comb begin
      cnt_d  = cnt_q;
      toggle = '0;
      if (keys_valid) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys_raw[i] == stable_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               cnt_d[i]  = '0;
               toggle[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
      stable_d = stable_q ^ toggle;
   end

   // A second toggle before queuing cancels the pending change; a fresh toggle
   // on the key being pushed this cycle re-arms its pending bit.
   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (pending_q[i] && !found) begin
            found   = 1'b1;
            sel_idx = KEY_IDX_W'(i);
         end
      end
      sel_mask = '0;
      if (found) begin
         sel_mask[sel_idx] = 1'b1;
      end
      push_evt   = make_evt(stable_q[sel_idx], sel_idx);
      pending_d  = (pending_q & ~sel_mask) ^ toggle;
      overflow_d = overflow_q;
      if (clr_overflow) begin
         overflow_d = 1'b0;
      end
      if (found && !push_ok) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_q   <= '0;
         pending_q  <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         stable_q   <= stable_d;
         pending_q  <= pending_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
      end
   end

   tm1638_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (found),
      .wr_data   (push_evt),
      .wr_accept (push_ok),
      .rd_valid  (evt_valid),
      .rd_ready  (evt_ready),
      .rd_data   (evt_data)
   );

   assign keys_stable = stable_q;
   assign overflow    = overflow_q;

endmodule

// File: doc/tm1638_key_events.md
TM1638_KEY_EVENTS -- requirements
Module: tm1638_key_events

Interface
REQ-001 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical scans needed to accept a key change (range 1..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event queue entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port keys_raw, input, 8: key bits S1..S8 from one completed TM1638 key scan, bit n = key n.
REQ-006 SHALL have port keys_valid, input, 1: one-cycle strobe; keys_raw is sampled only on this cycle.
REQ-007 SHALL have port keys_stable, output, 8: debounced key state.
REQ-008 SHALL have port evt_valid, output, 1: the queue head is presented.
REQ-009 SHALL have port evt_ready, input, 1: the consumer accepts the head.
REQ-010 SHALL have port evt_data, output, 4: {pressed, key_index[2:0]}; pressed = 1 for a press, 0 for a release.
REQ-011 SHALL have port overflow, output, 1: sticky flag, set when an event was lost.
REQ-012 SHALL have port clr_overflow, input, 1: synchronous clear of overflow.

Function
REQ-013 SHALL keep one 4-bit counter per key; on keys_valid, raw==stable resets it to 0, raw!=stable increments it.
REQ-014 SHALL, when a key counter reaches DEBOUNCE_SCANS-1 and the raw bit still differs, toggle the stable bit in the next cycle, clear the counter, and toggle that key's pending bit.
REQ-015 SHALL cancel the pending change with no event if a key toggles twice before its event is queued (pending toggles back to 0).
REQ-016 SHALL push at most one event per cycle, taking the lowest-index pending key; pressed = keys_stable[idx] at push time; that pending bit clears in the same cycle.
REQ-017 SHALL make evt_valid high on the cycle after a push into an empty FIFO (1-cycle latency); FIFO is first-word-fall-through.
REQ-018 SHALL pop on evt_valid && evt_ready; evt_data SHALL stay stable while evt_valid && !evt_ready.
REQ-019 SHALL, when full, accept a push only if a pop occurs in the same cycle; otherwise drop the event, clear its pending bit, and set overflow.
REQ-020 SHALL, when set and clear of overflow occur in the same cycle, leave overflow at 1 (set wins).
REQ-021 SHALL use FIFO pointers of log2(FIFO_DEPTH)+1 bits with wrap-around; full/empty come from the MSB comparison.
REQ-022 SHALL ignore keys_raw on cycles where keys_valid=0.

Reset
REQ-023 SHALL, on rst, asynchronously clear keys_stable, all counters, pending bits, FIFO pointers, evt_valid and overflow to 0.
REQ-024 SHALL discard queued and pending events when reset asserts mid-operation; after release, no events are produced for keys already held until they complete a full debounce.
REQ-025 SHALL require keys_valid to be low for at least one cycle after reset release.

Structure
REQ-026 SHALL place the event field widths and the pressed/released encoding constants in the shared tm1638 package.
REQ-027 SHALL implement the queue as one sub-module, tm1638_evt_fifo: a parameterised synchronous FWFT FIFO with the same clk/rst.
REQ-028 SHALL keep the debounce counters and the priority arbiter in tm1638_key_events.

Verification
REQ-029 SHALL cover: keys_raw=8'h01 on 4 strobes -> keys_stable=8'h01 after the 4th; one event 4'b1000; evt_ready=1 pops it.
REQ-030 SHALL cover: keys_raw alternating 8'h04 and 8'h00 on each strobe -> keys_stable stays 0; no events.
REQ-031 SHALL cover: keys_raw=8'h81 debounced, evt_ready=0 -> events 4'b1000 then 4'b1111 on consecutive cycles, lowest index first.
REQ-032 SHALL cover: evt_ready=0, 5 distinct key changes with FIFO_DEPTH=4 -> 4 events queued; overflow=1; the 5th event is lost; clr_overflow clears it.
REQ-033 SHALL cover: FIFO full, with a push and a pop in the same cycle -> no overflow; count stays 4; order preserved.
REQ-034 SHALL cover: rst asserted while 2 events are queued -> evt_valid=0 and keys_stable=0 immediately (asynchronous clear).
